// File: rtl/anffl_tex_color_unpacker.sv
// anffl_tex_color_unpacker
//   Accepts one packed texel word at a time and emits its texels as 32-bit RGBA
//   colours, LANES texels per output beat, using valid/ready on both sides.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no word held; in_ready=1, out_valid=0
//   EMIT  | word held; presenting the beat that starts at texel pointer ptr
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input word handshake
//   in_data            packed texel word, texel k at [k*bpp +: bpp]
//   in_format          5-bit format code
//   in_swap            swap R and B of every decoded texel of this word
//   out_valid/out_ready output beat handshake
//   out_rgba           lane i at [32i +: 32], {A,B,G,R}
//   out_mask           per-lane texel valid
//   out_last           final beat of the held word
//   out_err            held word has an unsupported format
module anffl_tex_color_unpacker #(
  parameter int DATA_W = 128,
  parameter int LANES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [4:0]            in_format,
  input  logic                  in_swap,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   out_rgba,
  output logic [LANES-1:0]      out_mask,
  output logic                  out_last,
  output logic                  out_err
);

  localparam logic [4:0] FMT_RGB_24     = 5'b00000;
  localparam logic [4:0] FMT_RGBA_32    = 5'b00100;
  localparam logic [4:0] FMT_RGB_16     = 5'b00001;
  localparam logic [4:0] FMT_RGBA_16    = 5'b00101;
  localparam logic [4:0] FMT_RGB_15     = 5'b01001;
  localparam logic [4:0] FMT_RGBA_15_PT = 5'b01101;
  localparam logic [4:0] FMT_R_8        = 5'b10011;
  localparam logic [4:0] FMT_R_16       = 5'b10111;

  // Pointer must hold up to N + 2*LANES - 1 without wrapping.
  localparam int PW = $clog2(DATA_W/8 + 2*LANES) + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] word_q;
  logic [4:0]        fmt_q;
  logic              swap_q;
  logic [PW-1:0]     ptr;

  logic [5:0]        bpp;
  logic [PW-1:0]     n_tex;
  logic              fmt_err;
  logic [PW-1:0]     tex_idx;
  logic [31:0]       tex_bits;

  function automatic logic [31:0] decode(input logic [4:0] fmt,
                                         input logic [31:0] tx,
                                         input logic swap);
    logic [7:0] r, g, b, a;
    // Default is the error colour (magenta, opaque).
    r = 8'hFF;
    g = 8'h00;
    b = 8'hFF;
    a = 8'hFF;
    case (fmt)
      FMT_RGB_24: begin
        r = tx[7:0];
        g = tx[15:8];
        b = tx[23:16];
      end
      FMT_RGBA_32: begin
        r = tx[7:0];
        g = tx[15:8];
        b = tx[23:16];
        a = tx[31:24];
      end
      FMT_RGB_16: begin
        r = {tx[4:0],   tx[4:2]};
        g = {tx[10:5],  tx[10:9]};
        b = {tx[15:11], tx[15:13]};
      end
      FMT_RGBA_16: begin
        r = {tx[3:0],   tx[3:0]};
        g = {tx[7:4],   tx[7:4]};
        b = {tx[11:8],  tx[11:8]};
        a = {tx[15:12], tx[15:12]};
      end
      FMT_RGB_15, FMT_RGBA_15_PT: begin
        r = {tx[4:0],   tx[4:2]};
        g = {tx[9:5],   tx[9:7]};
        b = {tx[14:10], tx[14:12]};
        if (fmt == FMT_RGBA_15_PT) a = {8{tx[15]}};
      end
      FMT_R_8: begin
        r = tx[7:0];
        b = 8'h00;
      end
      FMT_R_16: begin
        r = tx[15:8];
        b = 8'h00;
      end
      default: ;
    endcase
    if (swap) {r, b} = {b, r};
    return {a, b, g, r};
  endfunction

  always_comb begin
    bpp     = 6'd0;
    n_tex   = PW'(1);
    fmt_err = 1'b0;
    case (fmt_q)
      FMT_RGB_24:  begin bpp = 6'd24; n_tex = PW'(DATA_W/24); end
      FMT_RGBA_32: begin bpp = 6'd32; n_tex = PW'(DATA_W/32); end
      FMT_RGB_16, FMT_RGBA_16, FMT_RGB_15, FMT_RGBA_15_PT, FMT_R_16: begin
        bpp   = 6'd16;
        n_tex = PW'(DATA_W/16);
      end
      FMT_R_8:     begin bpp = 6'd8;  n_tex = PW'(DATA_W/8);  end
      default:     fmt_err = 1'b1;
    endcase
  end

  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && ((ptr + PW'(LANES)) >= n_tex);
  assign out_err   = out_valid && fmt_err;
  // A new word may enter on the same edge the last beat leaves.
  assign in_ready  = (state == IDLE) || (out_ready && out_last);

  // Error words have n_tex=1 and bpp=0, so lane 0 alone is unmasked and
  // decode() falls through to the error colour.
  always_comb begin
    out_rgba = '0;
    out_mask = '0;
    tex_idx  = '0;
    tex_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      tex_idx  = ptr + PW'(i);
      tex_bits = 32'(word_q >> (int'(tex_idx) * int'(bpp)));
      if (out_valid && (tex_idx < n_tex)) begin
        out_mask[i]          = 1'b1;
        out_rgba[32*i +: 32] = decode(fmt_q, tex_bits, swap_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      word_q <= '0;
      fmt_q  <= '0;
      swap_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      state  <= EMIT;
      ptr    <= '0;
      word_q <= in_data;
      fmt_q  <= in_format;
      swap_q <= in_swap;
    end else if (state == EMIT && out_ready) begin
      if (out_last) state <= IDLE;
      else          ptr   <= ptr + PW'(LANES);
    end
  end

endmodule

// File: tb/tb_anffl_tex_color_unpacker.sv
module tb_anffl_tex_color_unpacker;
  localparam int DW = 128;
  localparam int LN = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [4:0]      in_format;
  logic            in_swap;
  logic            out_valid;
  logic            out_ready;
  logic [LN*32-1:0] out_rgba;
  logic [LN-1:0]   out_mask;
  logic            out_last;
  logic            out_err;

  anffl_tex_color_unpacker #(.DATA_W(DW), .LANES(LN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_format(in_format), .in_swap(in_swap),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgba(out_rgba),
    .out_mask(out_mask), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LN*32-1:0] rgba;
    logic [LN-1:0]    mask;
    logic             last;
    logic             err;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    fmt;
    logic          swap;
  } word_t;

  beat_t sb[$];
  word_t pend[$];

  int checks   = 0;
  int failures = 0;
  int stall_left = 0;
  bit rdy_rand = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_bpp(input logic [4:0] f);
    case (f)
      5'b00000: return 24;
      5'b00100: return 32;
      5'b00001, 5'b00101, 5'b01001, 5'b01101, 5'b10111: return 16;
      5'b10011: return 8;
      default:  return 0;
    endcase
  endfunction

  // Bit-replicating widen of a w-bit channel to 8 bits.
  function automatic logic [7:0] xp(input int c, input int w);
    int v;
    v = (c << (8 - w)) | (c >> (2*w - 8));
    return v[7:0];
  endfunction

  function automatic logic [31:0] m_color(input logic [4:0] f, input logic [31:0] tx, input logic sw);
    logic [7:0] r, g, b, a, t;
    r = 8'hFF; g = 8'h00; b = 8'hFF; a = 8'hFF;
    case (f)
      5'b00000, 5'b00100: begin
        r = tx[7:0]; g = tx[15:8]; b = tx[23:16];
        if (f == 5'b00100) a = tx[31:24];
      end
      5'b00001: begin
        r = xp(int'(tx[4:0]), 5); g = xp(int'(tx[10:5]), 6); b = xp(int'(tx[15:11]), 5);
      end
      5'b00101: begin
        r = xp(int'(tx[3:0]), 4); g = xp(int'(tx[7:4]), 4);
        b = xp(int'(tx[11:8]), 4); a = xp(int'(tx[15:12]), 4);
      end
      5'b01001, 5'b01101: begin
        r = xp(int'(tx[4:0]), 5); g = xp(int'(tx[9:5]), 5); b = xp(int'(tx[14:10]), 5);
        if (f == 5'b01101) a = tx[15] ? 8'hFF : 8'h00;
      end
      5'b10011: begin r = tx[7:0];  g = 8'h00; b = 8'h00; end
      5'b10111: begin r = tx[15:8]; g = 8'h00; b = 8'h00; end
      default: ;
    endcase
    if (sw) begin t = r; r = b; b = t; end
    return {a, b, g, r};
  endfunction

  function automatic void push_word(input word_t w);
    int bpp, n;
    beat_t bt;
    logic [DW-1:0] s;
    logic [63:0] msk;
    bpp = m_bpp(w.fmt);
    if (bpp == 0) begin
      bt = '0;
      bt.rgba[31:0] = m_color(w.fmt, 32'h0, w.swap);
      bt.mask = 1;
      bt.last = 1'b1;
      bt.err  = 1'b1;
      sb.push_back(bt);
      return;
    end
    n   = DW / bpp;
    msk = (64'h1 << bpp) - 64'h1;
    for (int p = 0; p < n; p += LN) begin
      bt = '0;
      for (int i = 0; i < LN; i++) begin
        if (p + i < n) begin
          s = w.data >> ((p + i) * bpp);
          bt.mask[i] = 1'b1;
          bt.rgba[32*i +: 32] = m_color(w.fmt, s[31:0] & msk[31:0], w.swap);
        end
      end
      bt.last = (p + LN >= n);
      sb.push_back(bt);
    end
  endfunction

  task automatic step();
    logic exp_ir;
    @(negedge clk);
    if (pend.size() != 0) begin
      in_valid  = 1'b1;
      in_data   = pend[0].data;
      in_format = pend[0].fmt;
      in_swap   = pend[0].swap;
    end else begin
      in_valid  = 1'b0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_format = 5'($urandom);
      in_swap   = 1'($urandom);
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    exp_ir = (sb.size() == 0) || (sb[0].last && out_ready);
    chk("in_ready", in_ready, exp_ir);
    if (sb.size() != 0) begin
      chk("out_rgba", out_rgba, sb[0].rgba);
      chk("out_mask", out_mask, sb[0].mask);
      chk("out_last", out_last, sb[0].last);
      chk("out_err",  out_err,  sb[0].err);
      if (out_valid && out_ready) void'(sb.pop_front());
    end
    if (in_valid && in_ready) begin
      push_word(pend[0]);
      void'(pend.pop_front());
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() != 0 || sb.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 1, 0);
  endtask

  task automatic add(input logic [DW-1:0] d, input logic [4:0] f, input logic sw);
    word_t w;
    w.data = d; w.fmt = f; w.swap = sw;
    pend.push_back(w);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [4:0] fmts [9] = '{5'b00000, 5'b00100, 5'b00001, 5'b00101, 5'b01001,
                           5'b01101, 5'b10011, 5'b10111, 5'b00010};

  initial begin
    logic [DW-1:0] w24;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_format = '0; in_swap = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_rgba",  out_rgba,  0);
    chk("rst_out_mask",  out_mask,  0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_err",   out_err,   0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready",  in_ready,  1);

    // RGBA_32 reference word
    add(128'h44332211_14131211_0C0B0A09_04030201, 5'b00100, 1'b0);
    drain();

    // RGB_24: top byte must not matter
    w24 = rnd_word();
    add(w24, 5'b00000, 1'b0);
    w24[127:120] = ~w24[127:120];
    add(w24, 5'b00000, 1'b0);
    drain();

    // RGB_16 corner texels, plain and swapped
    w24 = rnd_word();
    w24[31:0] = 32'h001F_FFFF;
    add(w24, 5'b00001, 1'b0);
    add(w24, 5'b00001, 1'b1);
    drain();

    // Back-to-back then a 3-cycle stall
    add(rnd_word(), 5'b00100, 1'b0);
    add(rnd_word(), 5'b00101, 1'b0);
    add(rnd_word(), 5'b00100, 1'b1);
    repeat (3) step();
    stall_left = 3;
    drain();

    // Unsupported formats followed straight away by good words
    add(rnd_word(), 5'b00010, 1'b0);
    add(rnd_word(), 5'b00001, 1'b0);
    add(rnd_word(), 5'b11111, 1'b1);
    add(rnd_word(), 5'b10011, 1'b0);
    drain();

    // Random mix with random backpressure
    rdy_rand = 1;
    for (int k = 0; k < 40; k++)
      add(rnd_word(), fmts[$urandom_range(0, 8)], 1'($urandom));
    drain();
    rdy_rand = 0;

    // Reset after the first beat of a 4-beat word
    add(rnd_word(), 5'b01101, 1'b0);
    n = 0;
    while (!(pend.size() == 0 && sb.size() == 3) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("midrst_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_mask",  out_mask,  0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    add(rnd_word(), 5'b01001, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/anffl_tex_color_unpacker.md
ANFFL_TEX_COLOR_UNPACKER -- requirements
Module: anfFl_tex_colorUnpacker

Interface
REQ-001 Parameter DATA_W, default 128, input word width in bits; legal values 64, 128, 256.
REQ-002 Parameter LANES, default 2, texels emitted per output beat; legal values 1, 2, 4.
REQ-003 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  input word offered.
REQ-007 in_ready  out  1  block accepts word this cycle.
REQ-008 in_data  in  DATA_W  packed texel word; texel k occupies bits [k*bpp +: bpp].
REQ-009 in_format  in  5  format code: RGB_24=00000, RGBA_32=00100, RGB_16=00001, RGBA_16=00101, RGB_15=01001, RGBA_15_PT=01101, R_8_TILED=10011, R_16_TILED=10111.
REQ-010 in_swap  in  1  per-word mode: swap R and B of every decoded texel.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_rgba  out  LANES*32  lane i at [32i +: 32], bytes R[7:0], G[15:8], B[23:16], A[31:24].
REQ-014 out_mask  out  LANES  per-lane texel valid.
REQ-015 out_last  out  1  final beat of current word.
REQ-016 out_err  out  1  word had unsupported format; valid only with out_valid.

Function
REQ-017 Texels per word N = floor(DATA_W/bpp); bpp 32 for RGBA_32, 24 for RGB_24, 16 for 16/15-bit and R_16, 8 for R_8; RGB_24 leftover high bits ignored.
REQ-018 Handshake: transfer occurs on valid&&ready; out_valid, out_rgba, out_mask, out_last, out_err held stable while out_valid&&!out_ready.
REQ-019 Accepted word, format and swap registered; states IDLE (no word) and EMIT (word held, beat pointer p).
REQ-020 IDLE: in_ready=1; on accept -> EMIT, p=0; out_valid asserted the next cycle (latency 1).
REQ-021 Beat at pointer p carries texels p..p+LANES-1; out_mask bit i = (p+i < N); out_last = (p+LANES >= N).
REQ-022 Output beat transfer with !out_last: p += LANES, stay EMIT.
REQ-023 Output transfer with out_last: if in_valid same cycle, new word loaded, p=0, stay EMIT (no bubble); else -> IDLE, out_valid=0.
REQ-024 in_ready = IDLE || (out_valid && out_ready && out_last); never 1 otherwise.
REQ-025 RGB_24/RGBA_32: bytes copied R=b0, G=b1, B=b2; A=b3 for RGBA_32, else 8'hFF.
REQ-026 RGB_16 (565): R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}, A=8'hFF; R in bits [4:0].
REQ-027 RGBA_16 (4444): each channel nibble replicated {n,n}; R bits [3:0] ... A bits [15:12].
REQ-028 RGB_15/RGBA_15_PT: R,G,B 5-bit from [4:0],[9:5],[14:10], expanded {c,c[4:2]}; A={8{bit15}} for PT, else 8'hFF.
REQ-029 R_8: R=byte, G=B=0, A=8'hFF; R_16: R=bits[15:8], G=B=0, A=8'hFF.
REQ-030 Any other format: one beat, out_mask=1 in lane 0 only, lane 0 = R FF G 00 B FF A FF, out_last=1, out_err=1; masked lanes drive 0.
REQ-031 in_swap=1 exchanges final R and B bytes after expansion; A,G untouched; applies to error colour too.
REQ-032 Lanes with out_mask=0 drive 32'h0.

Reset
REQ-033 rst asserted at any time, including mid-word: state IDLE, p=0, out_valid=0, out_rgba=0, out_mask=0, out_last=0, out_err=0, in_ready=1 after release; held word discarded.
REQ-034 No output transfer completes on the cycle rst is asserted.

Verification
REQ-035 LANES=2, DATA_W=128, RGBA_32 word 0x44332211_..._04030201 (texel0=0x04030201): 2 beats, lane0 beat0 R01 G02 B03 A04, beat1 out_last=1, mask 11.
REQ-036 RGB_24, DATA_W=128, LANES=2: N=5, 3 beats, final mask 01, out_last on beat 3; bits [127:120] have no effect.
REQ-037 RGB_16 texel 0xFFFF -> FFFFFFFF; texel 0x001F -> R FF G00 B00 A FF; with in_swap=1 -> R00 B FF.
REQ-038 Back-to-back words with out_ready=1: out_valid continuous, in_ready high exactly on last-beat cycles; then out_ready=0 for 3 cycles: outputs stable, in_ready=0.
REQ-039 Format 00010 (compressed): single beat, lane0 FF00FF FF, out_err=1, next word accepted same cycle.
REQ-040 rst asserted mid-word (after beat 1 of 4): out_valid=0 immediately, in_ready=1 after release, next word decodes from texel 0.
